// File: rtl/cve2_load_store_resp_if.sv
// Handshake and data-bus bundle for cve2_load_store_resp. The slave modport is the
// response block itself; the master modport is the LSU/bus side driving it.
interface cve2_load_store_resp_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_type_i;
    logic        req_sign_ext_i;
    logic [1:0]  req_offset_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;
    logic [31:0] rf_wdata_lsu_o;
    logic        rf_we_lsu_o;
    logic        lsu_resp_valid_o;
    logic        lsu_resp_err_o;
    logic        busy_o;

    modport slave (
        input  req_valid_i, req_we_i, req_type_i, req_sign_ext_i, req_offset_i,
        input  data_rvalid_i, data_rdata_i, data_err_i,
        output req_ready_o, rf_wdata_lsu_o, rf_we_lsu_o, lsu_resp_valid_o, lsu_resp_err_o, busy_o
    );

    modport master (
        output req_valid_i, req_we_i, req_type_i, req_sign_ext_i, req_offset_i,
        output data_rvalid_i, data_rdata_i, data_err_i,
        input  req_ready_o, rf_wdata_lsu_o, rf_we_lsu_o, lsu_resp_valid_o, lsu_resp_err_o, busy_o
    );
endinterface

// File: rtl/cve2_load_store_resp.sv
// LSU response tracker: follows one- or two-beat bus transactions, merges/extends load data.
// Optional macro CVE2_LSU_RESP_REG_EN registers the completion outputs (one extra cycle of latency).

module cve2_load_store_resp_chk (
    input logic clk_i,
    input logic rst_i,
    input logic in_idle_i,
    input logic data_rvalid_i,
    input logic rf_we_i,
    input logic resp_err_i
);
    OnehotWeErr: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0({rf_we_i, resp_err_i}))
        else $error("OnehotWeErr: rf_we_lsu_o and lsu_resp_err_o both high");

    // A beat with nothing outstanding is dropped by the design; this only flags it.
    UnexpectedRvalid: assert property (@(posedge clk_i) disable iff (rst_i) !(in_idle_i && data_rvalid_i))
        else $warning("UnexpectedRvalid: data_rvalid_i seen with no transaction outstanding");
endmodule

module cve2_load_store_resp (
    input  logic                   clk_i,
    input  logic                   rst_i,
    cve2_load_store_resp_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        WAIT_FIRST = 2'b01,
        WAIT_LAST  = 2'b10
    } state_e;

    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_BYTE = 2'b10;

    state_e      state_q;
    logic        we_q;
    logic        sext_q;
    logic        split_q;
    logic        err_q;
    logic [1:0]  type_q;
    logic [1:0]  offset_q;
    logic [23:0] hold_q;

    logic        split_s;
    logic        ready_s;
    logic        accept_s;
    logic        resp_block_s;
    logic [31:0] shifted_s;
    logic [31:0] merged_s;
    logic [31:0] fmt_s;

    logic        resp_valid_d;
    logic        resp_err_d;
    logic        resp_we_d;
    logic [31:0] resp_wdata_d;

    assign ready_s  = (state_q == IDLE) & ~resp_block_s;
    assign accept_s = bus.req_valid_i & ready_s;

    // Misalignment check on the incoming request.
    always_comb begin
        split_s = 1'b0;
        case (bus.req_type_i)
            TYPE_HALF: split_s = (bus.req_offset_i == 2'd3);
            TYPE_BYTE: split_s = 1'b0;
            default:   split_s = (bus.req_offset_i != 2'd0);
        endcase
    end

    // Transaction FSM with captured request fields and first-beat holding register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            sext_q   <= 1'b0;
            split_q  <= 1'b0;
            err_q    <= 1'b0;
            type_q   <= 2'b00;
            offset_q <= 2'b00;
            hold_q   <= 24'h000000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        we_q     <= bus.req_we_i;
                        sext_q   <= bus.req_sign_ext_i;
                        split_q  <= split_s;
                        err_q    <= 1'b0;
                        type_q   <= bus.req_type_i;
                        offset_q <= bus.req_offset_i;
                        hold_q   <= 24'h000000;
                        state_q  <= split_s ? WAIT_FIRST : WAIT_LAST;
                    end
                end
                WAIT_FIRST: begin
                    if (bus.data_rvalid_i) begin
                        hold_q  <= 24'(bus.data_rdata_i >> {offset_q, 3'b000});
                        err_q   <= err_q | bus.data_err_i;
                        state_q <= WAIT_LAST;
                    end
                end
                WAIT_LAST: begin
                    if (bus.data_rvalid_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Align the final beat, splice in the held upper bytes of a split access, then extend.
    always_comb begin
        shifted_s = bus.data_rdata_i >> {offset_q, 3'b000};
        merged_s  = shifted_s;
        if (split_q) begin
            if (type_q == TYPE_HALF) begin
                merged_s = {16'h0000, bus.data_rdata_i[7:0], hold_q[7:0]};
            end else begin
                case (offset_q)
                    2'd1:    merged_s = {bus.data_rdata_i[7:0],  hold_q[23:0]};
                    2'd2:    merged_s = {bus.data_rdata_i[15:0], hold_q[15:0]};
                    2'd3:    merged_s = {bus.data_rdata_i[23:0], hold_q[7:0]};
                    default: merged_s = shifted_s;
                endcase
            end
        end else begin
            merged_s = shifted_s;
        end
        case (type_q)
            TYPE_BYTE: fmt_s = {{24{sext_q & merged_s[7]}},  merged_s[7:0]};
            TYPE_HALF: fmt_s = {{16{sext_q & merged_s[15]}}, merged_s[15:0]};
            default:   fmt_s = merged_s;
        endcase
    end

    // Completion decode in the final-beat cycle.
    always_comb begin
        resp_valid_d = (state_q == WAIT_LAST) & bus.data_rvalid_i;
        resp_err_d   = resp_valid_d & (err_q | bus.data_err_i);
        resp_we_d    = resp_valid_d & ~we_q & ~resp_err_d;
        resp_wdata_d = resp_we_d ? fmt_s : 32'h00000000;
    end

`ifdef CVE2_LSU_RESP_REG_EN
    logic        resp_valid_q;
    logic        resp_err_q;
    logic        resp_we_q;
    logic [31:0] resp_wdata_q;

    // Output stage; the next request is held off while it presents a response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_we_q    <= 1'b0;
            resp_wdata_q <= 32'h00000000;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_we_q    <= resp_we_d;
            resp_wdata_q <= resp_wdata_d;
        end
    end

    assign resp_block_s         = resp_valid_q;
    assign bus.lsu_resp_valid_o = resp_valid_q;
    assign bus.lsu_resp_err_o   = resp_err_q;
    assign bus.rf_we_lsu_o      = resp_we_q;
    assign bus.rf_wdata_lsu_o   = resp_wdata_q;
`else
    assign resp_block_s         = 1'b0;
    assign bus.lsu_resp_valid_o = resp_valid_d;
    assign bus.lsu_resp_err_o   = resp_err_d;
    assign bus.rf_we_lsu_o      = resp_we_d;
    assign bus.rf_wdata_lsu_o   = resp_wdata_d;
`endif

    assign bus.req_ready_o = ready_s;
    assign bus.busy_o      = (state_q != IDLE);

    cve2_load_store_resp_chk u_chk (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_idle_i     (state_q == IDLE),
        .data_rvalid_i (bus.data_rvalid_i),
        .rf_we_i       (bus.rf_we_lsu_o),
        .resp_err_i    (bus.lsu_resp_err_o)
    );
endmodule

// File: tb/tb_cve2_load_store_resp.sv
// Self-checking bench for cve2_load_store_resp: directed cases plus random transactions
// checked against a byte-addressed reference model.
module tb_cve2_load_store_resp;
`ifdef CVE2_LSU_RESP_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    localparam logic [1:0] T_W = 2'b00;
    localparam logic [1:0] T_H = 2'b01;
    localparam logic [1:0] T_B = 2'b10;
    localparam logic [1:0] T_R = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    cve2_load_store_resp_if bus ();

    cve2_load_store_resp dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [1:0] typ);
        if (typ == T_B) return 1;
        if (typ == T_H) return 2;
        return 4;
    endfunction

    // Reference: two consecutive bus words form an 8-byte window read little-endian from the offset.
    function automatic logic [31:0] model_load(input logic [1:0] typ, input logic sx, input logic [1:0] off,
                                               input logic [31:0] d1, input logic [31:0] d2);
        logic [7:0]  mem [8];
        logic [31:0] v;
        int          size;
        for (int i = 0; i < 4; i++) begin
            mem[i]     = d1[8*i +: 8];
            mem[4 + i] = d2[8*i +: 8];
        end
        size = size_of(typ);
        v = 32'h0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mem[int'(off) + i];
        if (size == 1 && sx && v[7])  v = v | 32'hFFFFFF00;
        if (size == 2 && sx && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, 32'(bus.lsu_resp_valid_o), 32'h0);
        check({tag, "_err"},   32'(bus.lsu_resp_err_o),   32'h0);
        check({tag, "_we"},    32'(bus.rf_we_lsu_o),      32'h0);
        check({tag, "_wdata"}, bus.rf_wdata_lsu_o,        32'h0);
    endtask

    // Present a request and hold it until the block takes it; returns at the next negedge.
    task automatic issue_req(input logic we, input logic [1:0] typ, input logic sx, input logic [1:0] off);
        int waited = 0;
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_type_i     = typ;
        bus.req_sign_ext_i = sx;
        bus.req_offset_i   = off;
        #1;
        while (!bus.req_ready_o && waited < 8) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("req_ready", 32'(bus.req_ready_o), 32'h1);
        check("busy_before", 32'(bus.busy_o), 32'h0);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        #1;
        check("busy_after_acc", 32'(bus.busy_o), 32'h1);
        check("ready_while_busy", 32'(bus.req_ready_o), 32'h0);
    endtask

    // Idle bus cycles while busy, with junk requests that must be ignored.
    task automatic gap_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.data_rvalid_i  = 1'b0;
            bus.req_valid_i    = 1'($urandom_range(0, 1));
            bus.req_we_i       = 1'($urandom_range(0, 1));
            bus.req_type_i     = 2'($urandom_range(0, 3));
            bus.req_offset_i   = 2'($urandom_range(0, 3));
            bus.req_sign_ext_i = 1'($urandom_range(0, 1));
            #1;
            check("gap_valid", 32'(bus.lsu_resp_valid_o), 32'h0);
            check("gap_busy", 32'(bus.busy_o), 32'h1);
        end
        bus.req_valid_i = 1'b0;
    endtask

    task automatic do_txn(input logic we, input logic [1:0] typ, input logic sx, input logic [1:0] off,
                          input logic [31:0] d1, input logic [31:0] d2, input logic e1, input logic e2,
                          input int gap);
        logic        split;
        logic        exp_err;
        logic        exp_we;
        logic [31:0] exp_wdata;
        split     = (int'(off) + size_of(typ)) > 4;
        exp_err   = split ? (e1 | e2) : e1;
        exp_we    = !we && !exp_err;
        exp_wdata = exp_we ? model_load(typ, sx, off, d1, d2) : 32'h0;

        issue_req(we, typ, sx, off);
        if (split) begin
            gap_cycles(gap);
            @(negedge clk);
            bus.data_rvalid_i = 1'b1;
            bus.data_rdata_i  = d1;
            bus.data_err_i    = e1;
            #1;
            check("first_beat_valid", 32'(bus.lsu_resp_valid_o), 32'h0);
        end
        gap_cycles(gap);
        @(negedge clk);
        bus.data_rvalid_i = 1'b1;
        bus.data_rdata_i  = split ? d2 : d1;
        bus.data_err_i    = split ? e2 : e1;
        #1;
        check("final_valid", 32'(bus.lsu_resp_valid_o), 32'(LAT == 0));
        check("final_err",   32'(bus.lsu_resp_err_o),    32'((LAT == 0) && exp_err));
        check("final_we",    32'(bus.rf_we_lsu_o),       32'((LAT == 0) && exp_we));
        check("final_wdata", bus.rf_wdata_lsu_o,         (LAT == 0) ? exp_wdata : 32'h0);
        @(negedge clk);
        bus.data_rvalid_i = 1'b0;
        bus.data_err_i    = 1'b0;
        bus.data_rdata_i  = $urandom;
        #1;
        check("next_valid", 32'(bus.lsu_resp_valid_o), 32'(LAT == 1));
        check("next_err",   32'(bus.lsu_resp_err_o),    32'((LAT == 1) && exp_err));
        check("next_we",    32'(bus.rf_we_lsu_o),       32'((LAT == 1) && exp_we));
        check("next_wdata", bus.rf_wdata_lsu_o,         (LAT == 1) ? exp_wdata : 32'h0);
        check("next_busy",  32'(bus.busy_o),            32'h0);
        check("next_ready", 32'(bus.req_ready_o),       32'(LAT == 0));
    endtask

    task automatic spurious_rvalid();
        int waited = 0;
        #1;
        while (!bus.req_ready_o && waited < 8) begin
            @(negedge clk);
            #1;
            waited++;
        end
        bus.data_rvalid_i = 1'b1;
        bus.data_rdata_i  = 32'hFFFFFFFF;
        bus.data_err_i    = 1'b1;
        #1;
        check_quiet("spur_now");
        check("spur_busy", 32'(bus.busy_o), 32'h0);
        @(negedge clk);
        bus.data_rvalid_i = 1'b0;
        bus.data_err_i    = 1'b0;
        #1;
        check_quiet("spur_next");
        check("spur_ready", 32'(bus.req_ready_o), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_type_i     = 2'b00;
        bus.req_sign_ext_i = 1'b0;
        bus.req_offset_i   = 2'b00;
        bus.data_rvalid_i  = 1'b0;
        bus.data_rdata_i   = 32'h0;
        bus.data_err_i     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(bus.req_ready_o), 32'h1);
        check("rst_busy",  32'(bus.busy_o),      32'h0);
        check_quiet("rst");
        rst = 1'b0;
        @(negedge clk);

        do_txn(1'b0, T_B, 1'b1, 2'd2, 32'h12853456, 32'h0, 1'b0, 1'b0, 0);
        do_txn(1'b0, T_H, 1'b0, 2'd2, 32'h80011234, 32'h0, 1'b0, 1'b0, 0);
        do_txn(1'b0, T_W, 1'b0, 2'd1, 32'hAABBCCDD, 32'h11223344, 1'b0, 1'b0, 1);
        do_txn(1'b0, T_H, 1'b1, 2'd3, 32'h80FFFFFF, 32'h55555580, 1'b1, 1'b0, 0);
        do_txn(1'b0, T_R, 1'b1, 2'd2, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b0, 0);
        do_txn(1'b1, T_W, 1'b0, 2'd0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 0);
        spurious_rvalid();

        // Reset while waiting for the first beat of a split word.
        issue_req(1'b0, T_W, 1'b0, 2'd3);
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(bus.req_ready_o), 32'h1);
        check("midrst_busy",  32'(bus.busy_o),      32'h0);
        check_quiet("midrst");
        #1;
        rst = 1'b0;
        @(negedge clk);
        do_txn(1'b0, T_W, 1'b0, 2'd0, 32'h01234567, 32'h0, 1'b0, 1'b0, 0);

        for (int n = 0; n < 60; n++) begin
            do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), $urandom, $urandom,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
